display_scan_controller: RTL

DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

---
 rtl/display_pkg.sv | 33 +++
 rtl/hex_to_7seg.sv | 11 +
 rtl/display_scan_controller.sv | 108 ++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the four-digit seven-segment scan controller.
// Segment codes are active-low in {g,f,e,d,c,b,a} order.
package display_pkg;

    typedef logic [1:0] digit_idx_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    // Entry n holds the code for hex digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
        SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
    };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment decode.
module hex_to_7seg
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/display_scan_controller.sv
// Four-digit multiplexed seven-segment scan controller.
// Each digit owns a REFRESH_DIV-cycle slot whose first BLANK_CYCLES cycles keep
// every anode off to suppress ghosting. The displayed value is latched once per
// full scan so a digit never shows a half-updated number.
// Optional build macro: LEADING_ZERO_BLANK_EN (blanks leading zero digits 3..1).
module display_scan_controller
    import display_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    generate
        if (REFRESH_DIV < 4) begin : g_bad_refresh_div
            $error("display_scan_controller: REFRESH_DIV must be >= 4");
        end
        if (BLANK_CYCLES < 0 || BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_blank_cycles
            $error("display_scan_controller: BLANK_CYCLES must be in 0..REFRESH_DIV-1");
        end
    endgenerate

    logic [SW-1:0] slot_cnt;
    digit_idx_t    digit_idx;
    logic [15:0]   value_q;
    logic [3:0]    dp_q;
    logic          slot_wrap;
    logic          scan_wrap;
    logic          blank;
    logic [3:0]    nibble;
    logic [6:0]    seg_hex;
    logic [3:0]    lz_mask;

    assign slot_wrap = (slot_cnt == SW'(REFRESH_DIV - 1));
    assign scan_wrap = slot_wrap && (digit_idx == 2'd3);

    // Slot/digit counters; inputs are latched only when the scan returns to digit 0.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slot_cnt  <= '0;
            digit_idx <= 2'd0;
            value_q   <= 16'h0000;
            dp_q      <= 4'b0000;
        end else begin
            slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
            if (slot_wrap) begin
                digit_idx <= digit_idx + 2'd1;
            end
            if (scan_wrap) begin
                value_q <= value;
                dp_q    <= dp_in;
            end
        end
    end

    // With no guard interval the compare would be constant, so it is elaborated away.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign blank = 1'b0;
        end else begin : g_blank
            assign blank = (slot_cnt < SW'(BLANK_CYCLES));
        end
    endgenerate

    assign nibble = value_q[{digit_idx, 2'b00} +: 4];

    hex_to_7seg u_hex_to_7seg (
        .nibble (nibble),
        .seg    (seg_hex)
    );

    // Per-digit segment suppression for leading zeros (digit 0 always shown).
    always_comb begin
        lz_mask = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
        lz_mask[3] = (value_q[15:12] == 4'h0);
        lz_mask[2] = (value_q[15:8]  == 8'h00);
        lz_mask[1] = (value_q[15:4]  == 12'h000);
`endif
    end

    // Registered outputs, one cycle behind the counter state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else if (blank) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << digit_idx);
            seg <= lz_mask[digit_idx] ? SEG_BLANK : seg_hex;
            dp  <= ~dp_q[digit_idx];
        end
    end

endmodule
